mem_stream_reader: RTL

Streaming read engine that sits directly upstream of the compute datapath and drives one read port of the shared multi-port scratchpad memory. On a start command it walks an address sequence (base, length, optional stride), reads each word through the memory's combinational read path, and delivers the words in order on a valid/ready output stream with a last-beat marker. It owns no storage beyond a single output register, and it never writes memory.

---
 rtl/mem_stream_reader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: streaming read engine for one scratchpad read port.
// Walks base/len/stride, reads through the combinational read path and
// delivers words on a valid/ready stream with a last-beat marker.
// Optional feature macro: MEM_STREAM_READER_STRIDE_EN (stride_i honoured;
// otherwise the address increment is fixed at 1).
module mem_stream_reader #(
   parameter int unsigned DataWidth = 8,
   parameter int unsigned DataDepth = 4096,
   parameter int unsigned AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
   parameter int unsigned LenWidth  = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic [AddrWidth-1:0]        base_addr_i,
   input  logic [LenWidth-1:0]         len_i,
   input  logic [AddrWidth-1:0]        stride_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [AddrWidth-1:0]        mem_addr_o,
   output logic                        mem_we_o,
   output logic [DataWidth-1:0]        mem_wr_data_o,
   input  logic signed [DataWidth-1:0] mem_rd_data_i,
   output logic signed [DataWidth-1:0] out_data_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic                        out_last_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                      state;
   logic [AddrWidth-1:0]        cur_addr;
   logic [AddrWidth-1:0]        step;
   logic [LenWidth-1:0]         remaining;
   logic signed [DataWidth-1:0] out_data;
   logic                        out_valid;
   logic                        out_last;
   logic                        done;
   logic                        load;

`ifdef MEM_STREAM_READER_STRIDE_EN
   logic [AddrWidth-1:0]        stride;
   assign step = stride;
`else
   // stride_i has no function in this build
   logic [AddrWidth-1:0]        unused_stride;
   assign unused_stride = stride_i;
   assign step          = AddrWidth'(1);
`endif

   // Output register may be reloaded when empty or when its beat is being taken
   assign load = !out_valid || out_ready_i;

   // Main FSM: address walk, output register and done pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= StIdle;
         cur_addr  <= '0;
         remaining <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
`ifdef MEM_STREAM_READER_STRIDE_EN
         stride    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start_i) begin
                  cur_addr  <= base_addr_i;
                  remaining <= len_i;
`ifdef MEM_STREAM_READER_STRIDE_EN
                  stride    <= stride_i;
`endif
                  // Zero-length transfer completes without producing beats
                  if (len_i != '0) begin
                     state <= StRun;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (load) begin
                  out_data  <= mem_rd_data_i;
                  out_valid <= 1'b1;
                  out_last  <= (remaining == LenWidth'(1));
                  cur_addr  <= cur_addr + step;
                  remaining <= remaining - LenWidth'(1);
                  if (remaining == LenWidth'(1)) begin
                     state <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (out_valid && out_ready_i) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  done      <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Outputs derived directly from registered state
   always_comb begin
      busy_o        = (state != StIdle);
      done_o        = done;
      mem_addr_o    = (state == StIdle) ? '0 : cur_addr;
      mem_we_o      = 1'b0;
      mem_wr_data_o = '0;
      out_data_o    = out_data;
      out_valid_o   = out_valid;
      out_last_o    = out_last;
   end

endmodule
